// File: rtl/byte_queue.sv
// byte_queue: circular byte FIFO fed by a four-phase ready/ack handshake. Dequeue latency is 1 clock. A full queue stalls the producer
// by holding ack_out low; define QUEUE_DROP_OLDEST_EN to overwrite the oldest byte instead.
module byte_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clock_10KHZ,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       data_ready_in,
  output logic                       ack_out,
  input  logic                       dequeue_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid_out,
  output logic [$clog2(DEPTH+1)-1:0] len_out,
  output logic                       full_out,
  output logic                       empty_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

`ifdef QUEUE_DROP_OLDEST_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  typedef enum logic {IDLE, ACK} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [LW-1:0]     len_nxt;
  logic              wr_en;
  logic              rd_en;
  logic              drop;
  logic              rd_adv;

  // Full/empty come from registered occupancy, so a same-cycle dequeue never frees room for a write.
  assign wr_en  = (state == IDLE) && data_ready_in && (!full_out || DROP_EN);
  assign rd_en  = dequeue_in && !empty_out;
  assign drop   = wr_en && full_out;
  assign rd_adv = rd_en || drop;

  always_ff @(posedge clock_10KHZ or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (wr_en) state_nxt = ACK;
      ACK:  if (!data_ready_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack_out = (state == ACK);
  end

  always_comb begin
    len_nxt = len_out;
    case ({wr_en, rd_adv})
      2'b10:   len_nxt = len_out + LW'(1);
      2'b01:   len_nxt = len_out - LW'(1);
      default: len_nxt = len_out;
    endcase
  end

  always_ff @(posedge clock_10KHZ) begin
    if (wr_en) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clock_10KHZ or negedge reset) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      len_out        <= '0;
      full_out       <= 1'b0;
      empty_out      <= 1'b1;
      data_out       <= '0;
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= rd_en;
      if (rd_en) begin
        data_out <= mem[rd_ptr];
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      len_out   <= len_nxt;
      full_out  <= (len_nxt == LW'(DEPTH));
      empty_out <= (len_nxt == '0);
    end
  end

endmodule

// File: doc/byte_queue.md
Name: byte_queue

Overview:
- Downstream consumer of the serial-to-byte deserializer.
- Accepts completed bytes through a four-phase ready/ack handshake and stores them in a circular FIFO.
- Releases bytes one at a time on a dequeue request.
- Runs entirely in the 10 kHz domain. Every handshake input is level-held by the producer, so no single-cycle pulse ever crosses domains.

Parameters:
- DEPTH, 8, number of byte entries; must be a power of two, at least 2.
- WIDTH, 8, bits per entry.

Ports:
- clock_10KHZ  input  1  queue clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low; 0 clears the block immediately, release synchronous to clock_10KHZ.
- data_in  input  WIDTH  byte from deserializer; stable while data_ready_in=1.
- data_ready_in  input  1  producer has a byte; held high until ack_out seen.
- ack_out  output  1  byte captured; held until data_ready_in falls.
- dequeue_in  input  1  consumer requests head byte; sampled each cycle.
- data_out  output  WIDTH  last dequeued byte; holds value between dequeues.
- data_valid_out  output  1  one-cycle pulse: data_out updated this cycle.
- len_out  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- full_out  output  1  len_out==DEPTH.
- empty_out  output  1  len_out==0.

Behaviour:
- Reset (reset=0, async): all outputs clear immediately.
  - data_out=0, data_valid_out=0, ack_out=0, len_out=0, full_out=0, empty_out=1.
  - Read/write pointers=0, handshake FSM=IDLE.
  - Reset mid-handshake discards the byte in flight; the producer re-handshakes after its own reset.
- Storage: DEPTH x WIDTH register array.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Occupancy is held in a separate counter, not derived from pointers.
- Handshake FSM (states IDLE, ACK):
  - IDLE -> ACK: when data_ready_in=1 and not full. Same edge writes data_in at wr_ptr, increments wr_ptr and len. ack_out=1 from the next cycle.
  - IDLE, data_ready_in=1 and full: no write, ack_out stays 0, stay IDLE; the producer stalls.
  - ACK: ack_out=1; no further write while in ACK, even if data_ready_in stays high.
  - ACK -> IDLE: when data_ready_in=0; ack_out=0 on the following cycle.
  - Guarantees exactly one write per data_ready_in high phase.
- Dequeue:
  - dequeue_in=1 and not empty: data_out<=mem[rd_ptr], rd_ptr++, len--, data_valid_out=1 for one cycle. Latency one clock from the sampled request.
  - dequeue_in=1 and empty: ignored; data_out holds, data_valid_out=0, len stays 0 (no underflow).
  - dequeue_in held high drains one byte per cycle.
- Simultaneous write and dequeue in the same cycle:
  - Both occur; len unchanged.
  - When full, a same-cycle dequeue does NOT permit the write; the full decision uses the registered len. The write proceeds on the next IDLE cycle.
  - When empty, the byte written is not dequeued the same cycle; dequeue sees empty. Empty write-through is not allowed.
- full_out and empty_out are registered-consistent with len_out, updated the same edge.
- len_out never exceeds DEPTH and never wraps below 0.

Optional Feature:
- Macro QUEUE_DROP_OLDEST_EN.
- Defined: with data_ready_in=1 in IDLE while full, the write is accepted.
  - The byte at rd_ptr is discarded (rd_ptr++), the new byte is written, and len stays DEPTH.
  - ack_out follows normally; the producer never stalls.
  - If dequeue_in=1 the same cycle, the head is output normally and the write proceeds; rd_ptr advances once.
- Undefined: full stalls the producer exactly as in Behaviour.

Test Plan:
- Reset release, then handshake data_in=8'hA5: ack_out=1 one cycle after data_ready_in=1, stays 1 until data_ready_in drops, falls the next cycle. len_out=1, empty_out=0.
- Hold data_ready_in=1 for 10 cycles with one byte: exactly one write, len_out=1.
- Enqueue 8'h01..8'h08: full_out=1, len_out=8. A ninth request gets no ack. Dequeue once: ninth byte then accepted and acked. With QUEUE_DROP_OLDEST_EN, the ninth byte is acked immediately and dequeues return 8'h02..8'h09.
- Enqueue 0x11, 0x22, 0x33, then dequeue_in high for 5 cycles: data_out 0x11, 0x22, 0x33 with data_valid_out pulses on 3 consecutive cycles. Extra dequeues give no pulse, data_out holds 0x33, len_out=0.
- Fill to 4, then assert a capture and a dequeue on the same edge: len_out stays 4, correct head emitted. Repeat past pointer wrap (20 bytes total): FIFO order preserved.
- Assert reset=0 while ack_out=1 with len_out=5: outputs clear asynchronously before the next clock edge, empty_out=1. The first byte after release reads back first.
